traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  YEL_MIN, 3, minimum consecutive sampled yellow cycles per lamp
  ALLRED_MIN, 2, minimum consecutive sampled all-red cycles before CR green
  CNT_W, 8, width of duration counters and cycle_cnt
REQ-002 Lamp encoding SHALL be RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 is illegal.
REQ-003 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, all state on rising edge
  clear  in  1  asynchronous active-low reset
  CR  in  2  country-road lamp code from the controller
  HW  in  2  highway lamp code from the controller
  X  in  1  country-road car sensor, same signal the controller sees
  fault_ack  in  1  clears the latched fault
  fault  out  1  sticky fault flag
  fault_code  out  3  code of first fault since last clear/ack
  phase  out  3  decoded light phase
  cycle_cnt  out  CNT_W  completed full light cycles

Function
REQ-004 Each rising edge SHALL sample CR, HW and X and compare them with the registered previous-cycle values cr_q, hw_q, x_q; all outputs are registered, one cycle latency.
REQ-005 phase SHALL decode the sampled {CR,HW}: (R,G)=0 HW_GO; (R,Y)=1 HW_YEL; (R,R)=2 ALL_RED; (G,R)=3 CR_GO; (Y,R)=4 CR_YEL; any other pair=7 INVALID.
REQ-006 Legal per-lamp transitions SHALL be hold, G->Y, Y->R, R->G; any other change is illegal.
REQ-007 Yellow counters (one per lamp) SHALL count consecutive sampled yellow cycles, saturate at 2^CNT_W-1, reset to 0 on any non-yellow sample.
REQ-008 All-red counter SHALL count consecutive sampled (R,R) cycles, saturate, reset to 0 on any other pair.
REQ-009 Fault codes, detected on the sampling edge:
  1 ILLEGAL_CODE: CR or HW == 2'b11
  2 CONFLICT: CR and HW both non-red
  3 BAD_TRANSITION: REQ-006 violated on either lamp
  4 SHORT_YELLOW: lamp goes Y->R with its yellow count < YEL_MIN
  5 SHORT_ALLRED: CR goes R->G with all-red count < ALLRED_MIN
  6 UNREQUESTED_EXIT: HW goes G->Y while x_q == 0
REQ-010 Simultaneous faults SHALL record the lowest code.
REQ-011 fault SHALL set on the first detected fault and hold; fault_code SHALL hold the first code and ignore later faults until cleared.
REQ-012 fault_ack high SHALL clear fault and fault_code to 0 on the next edge; a fault detected on that same edge SHALL win (set dominates ack).
REQ-013 The CR->HW handover (Y,R)->(R,G) SHALL be legal without an all-red interval.
REQ-014 cycle_cnt SHALL increment by 1 on each edge where the sampled pair changes from CR_YEL to HW_GO with no fault detected on that edge; it wraps from 2^CNT_W-1 to 0.
REQ-015 Monitoring SHALL continue after a fault (phase and counters keep updating).

Reset
REQ-016 clear low SHALL immediately force: fault=0, fault_code=0, phase=2, cycle_cnt=0, cr_q=hw_q=RED, x_q=0, all duration counters 0.
REQ-017 The first edge after reset release SHALL treat (R,R) as the previous pair; (R,R)->(R,G) SHALL be legal.
REQ-018 Asserting clear mid-cycle SHALL abandon all in-progress counts with no fault reported.

Verification
REQ-019 Legal cycle: (R,G) x4 with X=0, X=1 one cycle, (R,Y) x3, (R,R) x2, (G,R) x5, (Y,R) x3, (R,G) -> fault=0 throughout, phase 0,1,2,3,4,0 one cycle after each change, cycle_cnt=1.
REQ-020 Conflict: drive (G,G) after reset -> fault=1, fault_code=1? no: code 2 (CONFLICT, 2'b10 legal); drive (R,3) -> code 1 only if no prior fault.
REQ-021 Short yellow: (R,Y) x2 then (R,R) with YEL_MIN=3 -> fault_code=4 on that edge; subsequent (R,R) x1 -> (G,R) also short all-red but fault_code stays 4.
REQ-022 Unrequested exit: (R,G) with X=0, then (R,Y) -> fault_code=6; same edge with fault_ack=1 -> fault remains 1, code 6.
REQ-023 Ack and wrap: after fault, fault_ack one cycle with legal inputs -> fault=0, code=0; preload 255 legal cycles -> cycle_cnt 255 -> 0 on next CR_YEL->HW_GO.
REQ-024 Reset mid-yellow: (R,Y) x2, pulse clear low, release with (R,G) -> no fault, phase=0, cycle_cnt=0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks a two-road traffic light controller for illegal codes, conflicts,
// bad sequencing and short yellow/all-red intervals, and counts completed light cycles.
module traffic_light_monitor #(
    parameter int YEL_MIN    = 3,
    parameter int ALLRED_MIN = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       CR,
    input  logic [1:0]       HW,
    input  logic             X,
    input  logic             fault_ack,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] cycle_cnt
);
    localparam logic [1:0]       RED = 2'b00, YEL = 2'b01, GRN = 2'b10;
    localparam logic [CNT_W-1:0] YEL_C = CNT_W'(YEL_MIN), ALLRED_C = CNT_W'(ALLRED_MIN);

    logic [1:0]       r_cr_q, r_hw_q;
    logic             r_x_q, r_fault;
    logic [2:0]       r_code, r_phase;
    logic [CNT_W-1:0] r_yel_cr, r_yel_hw, r_allred, r_cycle;
    logic             w_illegal, w_conflict, w_bad, w_short_y, w_short_ar, w_unreq, w_cycle;
    logic [2:0]       w_code, w_phase;

    function automatic logic legal(input logic [1:0] p, input logic [1:0] c);
        return c == p || (p == GRN && c == YEL) || (p == YEL && c == RED) || (p == RED && c == GRN);
    endfunction

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_illegal  = CR == 2'b11 || HW == 2'b11;
        w_conflict = CR != RED && HW != RED;
        w_bad      = !legal(r_cr_q, CR) || !legal(r_hw_q, HW);
        w_short_y  = (r_cr_q == YEL && CR == RED && r_yel_cr < YEL_C) ||
                     (r_hw_q == YEL && HW == RED && r_yel_hw < YEL_C);
        w_short_ar = r_cr_q == RED && CR == GRN && r_allred < ALLRED_C;
        w_unreq    = r_hw_q == GRN && HW == YEL && !r_x_q;
        w_code     = w_illegal ? 3'd1 : w_conflict ? 3'd2 : w_bad ? 3'd3 :
                     w_short_y ? 3'd4 : w_short_ar ? 3'd5 : w_unreq ? 3'd6 : 3'd0;
        w_phase    = {CR, HW} == {RED, GRN} ? 3'd0 : {CR, HW} == {RED, YEL} ? 3'd1 :
                     {CR, HW} == {RED, RED} ? 3'd2 : {CR, HW} == {GRN, RED} ? 3'd3 :
                     {CR, HW} == {YEL, RED} ? 3'd4 : 3'd7;
        w_cycle    = {r_cr_q, r_hw_q} == {YEL, RED} && {CR, HW} == {RED, GRN} && w_code == 3'd0;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_cr_q   <= RED;
            r_hw_q   <= RED;
            r_x_q    <= 1'b0;
            r_yel_cr <= '0;
            r_yel_hw <= '0;
            r_allred <= '0;
            r_fault  <= 1'b0;
            r_code   <= 3'd0;
            r_phase  <= 3'd2;
            r_cycle  <= '0;
        end else begin
            r_cr_q   <= CR;
            r_hw_q   <= HW;
            r_x_q    <= X;
            r_yel_cr <= CR == YEL ? inc_sat(r_yel_cr) : '0;
            r_yel_hw <= HW == YEL ? inc_sat(r_yel_hw) : '0;
            r_allred <= {CR, HW} == {RED, RED} ? inc_sat(r_allred) : '0;
            r_phase  <= w_phase;
            r_cycle  <= w_cycle ? r_cycle + 1'b1 : r_cycle;
            // Once latched, only an ack reopens the flag; a fault on the ack edge re-latches.
            if (fault_ack || !r_fault) begin
                r_fault <= w_code != 3'd0;
                r_code  <= w_code;
            end
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_code;
    assign phase      = r_phase;
    assign cycle_cnt  = r_cycle;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scoreboard bench; a history-based reference model predicts every
// registered output and a monitor compares one cycle after each sampled edge.
module tb_traffic_light_monitor;
    localparam int YEL_MIN = 3, ALLRED_MIN = 2;
    localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10;

    logic       clk = 1'b0, clear, X, fault_ack, fault;
    logic [1:0] CR, HW;
    logic [2:0] fault_code, phase;
    logic [7:0] cycle_cnt;

    traffic_light_monitor dut (
        .clk(clk), .clear(clear), .CR(CR), .HW(HW), .X(X), .fault_ack(fault_ack),
        .fault(fault), .fault_code(fault_code), .phase(phase), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       f;
        logic [2:0] c;
        logic [2:0] p;
        logic [7:0] n;
        int         id;
    } exp_t;

    exp_t       q[$];
    logic [3:0] hist[$];
    logic       mx;
    bit         mf;
    int         mcode, mcyc, nstep, tests, fails;

    function automatic int run_len(int sel, logic [1:0] v);
        int n = 0;
        for (int i = hist.size() - 1; i >= 0 && n < 255; i--) begin
            if (!(sel == 0 ? hist[i][3:2] == v : sel == 1 ? hist[i][1:0] == v : hist[i] == 4'b0000))
                break;
            n++;
        end
        return n;
    endfunction

    function automatic bit ok(logic [1:0] p, logic [1:0] c);
        logic [3:0] pc = {p, c};
        return p == c || pc == 4'b1001 || pc == 4'b0100 || pc == 4'b0010;
    endfunction

    task automatic drive_and_model(logic [1:0] cr, logic [1:0] hw, logic x, logic ack);
        logic [1:0] pcr, phw;
        logic [2:0] ph;
        int code;
        CR = cr; HW = hw; X = x; fault_ack = ack;
        pcr = hist.size() != 0 ? hist[$][3:2] : R;
        phw = hist.size() != 0 ? hist[$][1:0] : R;
        if (cr == 2'b11 || hw == 2'b11) code = 1;
        else if (cr != R && hw != R) code = 2;
        else if (!ok(pcr, cr) || !ok(phw, hw)) code = 3;
        else if ((pcr == Y && cr == R && run_len(0, Y) < YEL_MIN) ||
                 (phw == Y && hw == R && run_len(1, Y) < YEL_MIN)) code = 4;
        else if (pcr == R && cr == G && run_len(2, R) < ALLRED_MIN) code = 5;
        else if (phw == G && hw == Y && !mx) code = 6;
        else code = 0;
        if (code != 0 && (!mf || ack)) begin mf = 1; mcode = code; end
        else if (ack) begin mf = 0; mcode = 0; end
        case ({cr, hw})
            {R, G}: ph = 3'd0;
            {R, Y}: ph = 3'd1;
            {R, R}: ph = 3'd2;
            {G, R}: ph = 3'd3;
            {Y, R}: ph = 3'd4;
            default: ph = 3'd7;
        endcase
        if (pcr == Y && phw == R && cr == R && hw == G && code == 0) mcyc = (mcyc + 1) % 256;
        hist.push_back({cr, hw});
        if (hist.size() > 300) void'(hist.pop_front());
        mx = x;
        nstep++;
        q.push_back('{mf, 3'(mcode), ph, 8'(mcyc), nstep});
    endtask

    task automatic step(logic [1:0] cr, logic [1:0] hw, logic x = 1'b0, logic ack = 1'b0);
        @(negedge clk);
        drive_and_model(cr, hw, x, ack);
    endtask

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic after();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_then(logic [1:0] cr, logic [1:0] hw, logic x);
        @(negedge clk);
        clear = 1'b0; CR = R; HW = R; X = 1'b0; fault_ack = 1'b0;
        #1;
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_phase", phase, 2);
        chk("rst_cycle", cycle_cnt, 0);
        hist.delete(); q.delete();
        mx = 1'b0; mf = 0; mcode = 0; mcyc = 0;
        @(negedge clk);
        clear = 1'b1;
        drive_and_model(cr, hw, x, 1'b0);
    endtask

    task automatic tail();
        repeat (3) step(R, Y);
        repeat (2) step(R, R);
        step(G, R);
        repeat (3) step(Y, R);
    endtask

    task automatic rstep(logic [1:0] cr, logic [1:0] hw, logic x);
        if ($urandom_range(0, 9) == 0) step(2'($urandom), 2'($urandom), 1'($urandom), 1'b0);
        step(cr, hw, x, $urandom_range(0, 5) == 0);
    endtask

    task automatic random_cycle();
        int n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) rstep(R, G, i == n - 1 ? ($urandom_range(0, 7) != 0) : 1'($urandom));
        repeat ($urandom_range(2, 5)) rstep(R, Y, 1'($urandom));
        repeat ($urandom_range(1, 3)) rstep(R, R, 1'($urandom));
        repeat ($urandom_range(1, 4)) rstep(G, R, 1'($urandom));
        repeat ($urandom_range(2, 4)) rstep(Y, R, 1'($urandom));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            if ({fault, fault_code, phase, cycle_cnt} !== {e.f, e.c, e.p, e.n}) begin
                fails++;
                $display("FAIL out step %0d: got f=%0d code=%0d phase=%0d cyc=%0d, want f=%0d code=%0d phase=%0d cyc=%0d",
                         e.id, fault, fault_code, phase, cycle_cnt, e.f, e.c, e.p, e.n);
            end
        end
    end

    initial begin
        clear = 1'b0; CR = R; HW = R; X = 1'b0; fault_ack = 1'b0;
        tests = 0; fails = 0; nstep = 0;
        reset_then(R, G, 1'b0);
        repeat (3) step(R, G, 1'b0);
        step(R, G, 1'b1);
        repeat (3) step(R, Y);
        repeat (2) step(R, R);
        repeat (5) step(G, R);
        repeat (3) step(Y, R);
        step(R, G);
        after();
        chk("legal_cycle_cnt", cycle_cnt, 1);
        chk("legal_fault", fault, 0);
        chk("legal_phase", phase, 0);
        reset_then(G, G, 1'b0);
        after();
        chk("conflict_code", fault_code, 2);
        step(R, 2'b11);
        after();
        chk("conflict_holds", fault_code, 2);
        reset_then(R, G, 1'b1);
        repeat (2) step(R, Y);
        step(R, R);
        after();
        chk("short_yel_code", fault_code, 4);
        step(G, R);
        after();
        chk("short_ar_keeps4", fault_code, 4);
        reset_then(R, G, 1'b0);
        step(R, Y, 1'b0, 1'b1);
        after();
        chk("unreq_fault", fault, 1);
        chk("unreq_code", fault_code, 6);
        step(R, Y, 1'b0, 1'b1);
        after();
        chk("ack_fault", fault, 0);
        chk("ack_code", fault_code, 0);
        reset_then(R, G, 1'b1);
        tail();
        repeat (255) begin
            step(R, G, 1'b1);
            tail();
        end
        after();
        chk("wrap_255", cycle_cnt, 255);
        step(R, G, 1'b1);
        after();
        chk("wrap_0", cycle_cnt, 0);
        reset_then(R, G, 1'b1);
        repeat (2) step(R, Y);
        reset_then(R, G, 1'b0);
        after();
        chk("midrst_fault", fault, 0);
        chk("midrst_phase", phase, 0);
        chk("midrst_cycle", cycle_cnt, 0);
        reset_then(R, G, 1'b1);
        repeat (60) begin
            if ($urandom_range(0, 19) == 0) reset_then(R, G, 1'b1);
            random_cycle();
        end
        step(R, G, 1'b1);
        repeat (4) begin
            if (q.size() != 0) after();
        end
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
